// File: rtl/sram_controller.sv
// 32-bit load/store back end for an external 16-bit asynchronous SRAM.
// Each word access is split into two timed half-word phases, and the pipeline is stalled while they run.
module sram_controller #(
  parameter int ACCESS_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        ready,
  inout  wire  [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_WE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N
);

  localparam logic [3:0] LAST = 4'(ACCESS_CYCLES - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOW  = 2'd1;
  localparam logic [1:0] HIGH = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic        op_wr;
  logic [16:0] word;
  logic [31:0] wdata;

  logic        req;
  logic        phase;
  logic        last;
  logic [15:0] half_data;
  logic        unused_addr_bits;

  assign req       = wr_en | rd_en;
  assign phase     = (state == LOW) || (state == HIGH);
  assign last      = (cnt == LAST);
  assign half_data = (state == HIGH) ? wdata[31:16] : wdata[15:0];

  // The low two byte-offset bits and everything above the 512 KB window are deliberately dropped.
  assign unused_addr_bits = ^{address[31:19], address[1:0]};

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values,
  // which is what lets the read capture see SRAM_DQ from the final cycle of a phase.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      op_wr    <= 1'b0;
      word     <= '0;
      wdata    <= '0;
      readData <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            op_wr <= wr_en;
            word  <= address[18:2];
            wdata <= writeData;
            cnt   <= '0;
            state <= LOW;
          end
        end
        LOW: begin
          if (last) begin
            cnt   <= '0;
            state <= HIGH;
            if (!op_wr) readData[15:0] <= SRAM_DQ;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        HIGH: begin
          if (last) begin
            cnt   <= '0;
            state <= DONE;
            if (!op_wr) readData[31:16] <= SRAM_DQ;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: every output written here gets a default first, so no path leaves one unassigned
  // and no latch is inferred.
  always_comb begin
    ready     = (state == DONE) || ((state == IDLE) && !req);
    SRAM_ADDR = '0;
    SRAM_WE_N = 1'b1;
    SRAM_OE_N = 1'b1;
    if (phase) begin
      SRAM_ADDR = {word, state == HIGH};
      // WE rises on the last cycle of a write phase while address and data stay put (hold time).
      SRAM_WE_N = !(op_wr && !last);
      SRAM_OE_N = op_wr;
    end
  end

  assign SRAM_DQ = (phase && op_wr) ? half_data : 16'hzzzz;

  assign SRAM_CE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;

endmodule
